// File: rtl/cmp_operand_serializer.sv
// Feeds a bit-serial unsigned comparator: captures A/B on start, presents them MSB-first.
// Latency: WIDTH+2 cycles from accept to done. With CMP_SER_EARLY_EXIT_EN it is 2 + the first differing bit position.
// No backpressure: start is only accepted in IDLE or DONE and is ignored while busy.
module cmp_operand_serializer #(
    parameter  int WIDTH = 32,
    localparam int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             busy,
    output logic             a_bit,
    output logic             b_bit,
    output logic             cmp_hold,
    output logic             cmp_clr,
    output logic             done,
    output logic [CNT_W-1:0] bit_cnt
);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, CLEAR, SHIFT, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic             accept;
    logic             early_exit;

    // DONE also accepts start so back-to-back compares need no IDLE gap
    assign accept = start && ((state == IDLE) || (state == DONE));

`ifdef CMP_SER_EARLY_EXIT_EN
    // the comparator locks on its first differing bit, so the rest is redundant
    assign early_exit = a_bit ^ b_bit;
`else
    assign early_exit = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            a_sh     <= '0;
            b_sh     <= '0;
            busy     <= 1'b0;
            a_bit    <= 1'b0;
            b_bit    <= 1'b0;
            cmp_hold <= 1'b1;
            cmp_clr  <= 1'b0;
            done     <= 1'b0;
            bit_cnt  <= '0;
        end else if (accept) begin
            a_sh     <= a_in;
            b_sh     <= b_in;
            bit_cnt  <= CNT_MAX;
            busy     <= 1'b1;
            cmp_clr  <= 1'b1;
            cmp_hold <= 1'b1;
            done     <= 1'b0;
            state    <= CLEAR;
        end else begin
            case (state)
                IDLE: begin
                    cmp_hold <= 1'b1;
                end
                CLEAR: begin
                    cmp_clr  <= 1'b0;
                    cmp_hold <= 1'b0;
                    a_bit    <= a_sh[WIDTH-1];
                    b_bit    <= b_sh[WIDTH-1];
                    a_sh     <= {a_sh[WIDTH-2:0], 1'b0};
                    b_sh     <= {b_sh[WIDTH-2:0], 1'b0};
                    state    <= SHIFT;
                end
                SHIFT: begin
                    if ((bit_cnt == '0) || early_exit) begin
                        cmp_hold <= 1'b1;
                        done     <= 1'b1;
                        state    <= DONE;
                    end else begin
                        a_bit   <= a_sh[WIDTH-1];
                        b_bit   <= b_sh[WIDTH-1];
                        a_sh    <= {a_sh[WIDTH-2:0], 1'b0};
                        b_sh    <= {b_sh[WIDTH-2:0], 1'b0};
                        bit_cnt <= bit_cnt - CNT_W'(1);
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cmp_operand_serializer.sv
// Directed bench for cmp_operand_serializer (WIDTH=32) driving a behavioural
// bit-serial comparator that locks on the first differing bit.
module tb_cmp_operand_serializer;
    localparam int WIDTH = 32;
`ifdef CMP_SER_EARLY_EXIT_EN
    localparam bit EE = 1'b1;
`else
    localparam bit EE = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic             busy, a_bit, b_bit, cmp_hold, cmp_clr, done;
    logic [4:0]       bit_cnt;

    logic lt, eq, gt;
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    cmp_operand_serializer #(.WIDTH(WIDTH)) dut (
        .clk(clk), .rst(rst), .start(start), .a_in(a_in), .b_in(b_in),
        .busy(busy), .a_bit(a_bit), .b_bit(b_bit), .cmp_hold(cmp_hold),
        .cmp_clr(cmp_clr), .done(done), .bit_cnt(bit_cnt)
    );

    always #5 clk = ~clk;

    // comparator: cleared by rst|cmp_clr, consumes a bit when op (cmp_hold) is 0
    always @(posedge clk or posedge rst) begin
        if (rst || cmp_clr) begin
            lt <= 1'b0; eq <= 1'b1; gt <= 1'b0;
        end else if (!cmp_hold && eq && (a_bit != b_bit)) begin
            eq <= 1'b0;
            gt <= a_bit;
            lt <= b_bit;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // accept at edge 0, then check cycles 1 and 2; returns in cycle 2
    task automatic start_cmp(input string tag, input logic [31:0] a, input logic [31:0] b);
        a_in  = a;
        b_in  = b;
        start = 1'b1;
        cyc   = 0;
        step();
        start = 1'b0;
        chk({tag, "_clr_c1"}, cmp_clr, 1);
        chk({tag, "_busy_c1"}, busy, 1);
        chk({tag, "_done_c1"}, done, 0);
        chk({tag, "_cnt_c1"}, bit_cnt, 31);
        step();
        chk({tag, "_clr_c2"}, cmp_clr, 0);
        chk({tag, "_hold_c2"}, cmp_hold, 0);
        chk({tag, "_abit_c2"}, a_bit, a[31]);
    endtask

    task automatic wait_done(input string tag, input int exp_cyc, input int exp_cnt,
                             input logic el, input logic ee, input logic eg);
        int n = 0;
        while (!done && n < 100) begin
            step();
            n++;
        end
        if (!done) begin
            chk({tag, "_done_timeout"}, 0, 1);
        end else begin
            chk({tag, "_done_cycle"}, cyc, exp_cyc);
            chk({tag, "_cnt"}, bit_cnt, exp_cnt);
            chk({tag, "_hold"}, cmp_hold, 1);
            chk({tag, "_clr"}, cmp_clr, 0);
            chk({tag, "_lt"}, lt, el);
            chk({tag, "_eq"}, eq, ee);
            chk({tag, "_gt"}, gt, eg);
        end
    endtask

    initial begin
        int seen;
        rst   = 1'b1;
        start = 1'b0;
        a_in  = '0;
        b_in  = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_abit", a_bit, 0);
        chk("rst_bbit", b_bit, 0);
        chk("rst_hold", cmp_hold, 1);
        chk("rst_clr", cmp_clr, 0);
        chk("rst_done", done, 0);
        chk("rst_cnt", bit_cnt, 0);
        rst = 1'b0;
        step();

        // reset in the middle of SHIFT aborts with no done pulse
        start_cmp("abort", 32'hFFFF_0000, 32'h0000_FFFF);
        repeat (4) step();
        chk("abort_hold_pre", cmp_hold, 0);
        rst = 1'b1;
        step();
        chk("abort_busy", busy, 0);
        chk("abort_hold", cmp_hold, 1);
        chk("abort_done", done, 0);
        chk("abort_cnt", bit_cnt, 0);
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (done || busy) seen++;
        end
        chk("abort_quiet", seen, 0);

        // equal operands always run the full width
        start_cmp("eq5", 32'h0000_0005, 32'h0000_0005);
        wait_done("eq5", 34, 0, 1'b0, 1'b1, 1'b0);
        step();
        chk("eq5_idle_busy", busy, 0);
        chk("eq5_idle_done", done, 0);
        step();

        // a<b decided at bit 1; a start pulse in cycle 5 must be ignored
        start_cmp("lt", 32'h0000_0001, 32'h0000_0002);
        repeat (3) step();
        a_in  = 32'hFFFF_FFFF;
        b_in  = 32'h0000_0000;
        start = 1'b1;
        step();
        start = 1'b0;
        chk("lt_busy_ign", busy, 1);
        chk("lt_clr_ign", cmp_clr, 0);
        wait_done("lt", EE ? 33 : 34, EE ? 1 : 0, 1'b1, 1'b0, 1'b0);
        step();
        step();

        // a>b decided at the MSB, then back-to-back start in the DONE cycle
        start_cmp("gt", 32'h8000_0000, 32'h7FFF_FFFF);
        wait_done("gt", EE ? 3 : 34, EE ? 31 : 0, 1'b0, 1'b0, 1'b1);
        start_cmp("b2b", 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        chk("b2b_cleared_gt", gt, 0);
        chk("b2b_cleared_eq", eq, 1);
        wait_done("b2b", 34, 0, 1'b0, 1'b1, 1'b0);
        step();
        chk("b2b_end_busy", busy, 0);
        chk("b2b_end_hold", cmp_hold, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
